// File: rtl/r2_stage_sched.sv
// Butterfly issue sequencer for an in-place 16-point radix-2 DIF FFT.
// Issues 4 stages x 8 butterflies, drains write-backs between stages.
module r2_stage_sched #(
    parameter int PIPE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [3:0] rd_addr1,
    output logic [3:0] rd_addr2,
    output logic [2:0] tw_idx,
    output logic [1:0] stage,
    output logic       wr_en,
    output logic [3:0] wr_addr1,
    output logic [3:0] wr_addr2
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t              state;
    logic [1:0]          s;
    logic [2:0]          b;
    logic [2:0]          wcnt;
    logic [PIPE-1:0][8:0] wpipe;

    // Returns {rd_addr1, rd_addr2, tw_idx} for stage st, butterfly bf.
    function automatic logic [10:0] bfly(input logic [1:0] st, input logic [2:0] bf);
        logic [3:0] span, pos, grp, a1, tw;
        span = 4'd8 >> st;
        pos  = {1'b0, bf} & (span - 4'd1);
        grp  = {1'b0, bf} >> (2'd3 - st);
        a1   = ((grp * span) << 1) + pos;
        tw   = pos << st;
        return {a1, a1 + span, tw[2:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the write-back pipe is reset too, so an abandoned run cannot leak a late wr_en.
            state    <= IDLE;
            s        <= '0;
            b        <= '0;
            wcnt     <= '0;
            wpipe    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            tw_idx   <= '0;
            stage    <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the pre-edge rd_* values.
            wpipe[0] <= {rd_en, rd_addr1, rd_addr2};
            for (int k = 1; k < PIPE; k++) wpipe[k] <= wpipe[k-1];

            // Read outputs default to 0; only issuing branches override them.
            rd_en    <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            tw_idx   <= '0;
            stage    <= '0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        s     <= '0;
                        b     <= '0;
                        rd_en <= 1'b1;
                        {rd_addr1, rd_addr2, tw_idx} <= bfly(2'd0, 3'd0);
                        stage <= 2'd0;
                    end
                end
                RUN: begin
                    b <= b + 3'd1;
                    if (b == 3'd7) begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end else begin
                        rd_en <= 1'b1;
                        {rd_addr1, rd_addr2, tw_idx} <= bfly(s, b + 3'd1);
                        stage <= s;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 3'd1;
                    // Last write of the stage is in this cycle; the next read lands after it.
                    if (wcnt == 3'(PIPE - 1)) begin
                        if (s == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            s     <= s + 2'd1;
                            rd_en <= 1'b1;
                            {rd_addr1, rd_addr2, tw_idx} <= bfly(s + 2'd1, 3'd0);
                            stage <= s + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {wr_en, wr_addr1, wr_addr2} = wpipe[PIPE-1];

endmodule

// File: tb/tb_r2_stage_sched.sv
// Directed bench for r2_stage_sched: PIPE=2 and PIPE=1 instances share stimulus.
module tb_r2_stage_sched;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic       busy2, done2, rd_en2, wr_en2;
    logic [3:0] ra1_2, ra2_2, wa1_2, wa2_2;
    logic [2:0] tw_2;
    logic [1:0] st_2;
    logic       busy1, done1, rd_en1, wr_en1;
    logic [3:0] ra1_1, ra2_1, wa1_1, wa2_1;
    logic [2:0] tw_1;
    logic [1:0] st_1;

    r2_stage_sched #(.PIPE(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr1(ra1_2), .rd_addr2(ra2_2), .tw_idx(tw_2), .stage(st_2),
        .wr_en(wr_en2), .wr_addr1(wa1_2), .wr_addr2(wa2_2)
    );
    r2_stage_sched #(.PIPE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr1(ra1_1), .rd_addr2(ra2_1), .tw_idx(tw_1), .stage(st_1),
        .wr_en(wr_en1), .wr_addr1(wa1_1), .wr_addr2(wa2_1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle logs; cycle 0 is the cycle in which start is first driven high.
    localparam int NLOG = 64;
    logic       re2_l[NLOG], we2_l[NLOG], dn2_l[NLOG], by2_l[NLOG];
    logic [3:0] ra1_l[NLOG], ra2_l[NLOG], wa1_l[NLOG], wa2_l[NLOG];
    logic [2:0] tw_l[NLOG];
    logic [1:0] st_l[NLOG];
    logic       re1_l[NLOG], we1_l[NLOG], dn1_l[NLOG];
    logic [3:0] r1a1_l[NLOG], r1a2_l[NLOG], w1a1_l[NLOG], w1a2_l[NLOG];

    task automatic run_log(input int ncyc, input bit hold, input bit pulse20);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || hold || (pulse20 && c == 20);
            @(negedge clk);
            re2_l[c] = rd_en2; ra1_l[c] = ra1_2; ra2_l[c] = ra2_2; tw_l[c] = tw_2; st_l[c] = st_2;
            we2_l[c] = wr_en2; wa1_l[c] = wa1_2; wa2_l[c] = wa2_2; dn2_l[c] = done2; by2_l[c] = busy2;
            re1_l[c] = rd_en1; r1a1_l[c] = ra1_1; r1a2_l[c] = ra2_1;
            we1_l[c] = wr_en1; w1a1_l[c] = wa1_1; w1a2_l[c] = wa2_1; dn1_l[c] = done1;
        end
        start = 1'b0;
    endtask

    function automatic logic [13:0] rdv(input int c);
        return {re2_l[c], ra1_l[c], ra2_l[c], tw_l[c], st_l[c]};
    endfunction

    function automatic logic [31:0] all_out2();
        return {busy2, done2, rd_en2, ra1_2, ra2_2, tw_2, st_2, wr_en2, wa1_2, wa2_2};
    endfunction

    // Hand-computed issue vectors for PIPE=2: cycle, addr1, addr2, twiddle, stage.
    int vec_c [9] = '{1, 2, 8, 11, 14, 15, 22, 31, 38};
    int vec_a1[9] = '{0, 1, 7, 0, 3, 8, 1, 0, 14};
    int vec_a2[9] = '{8, 9, 15, 4, 7, 12, 3, 1, 15};
    int vec_tw[9] = '{0, 1, 7, 0, 6, 0, 4, 0, 0};
    int vec_st[9] = '{0, 0, 0, 1, 1, 1, 2, 3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd, n_wr, n_dn, bad, n_rd1, n_wr1, late_wr1;
        int first_rd[4], last_wr[4], wr_seen;

        rst   = 1'b1;
        start = 1'b0;
        #3;
        check("reset_outputs_zero", all_out2(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", all_out2(), 32'd0);
        check("idle_busy1", busy1, 1'b0);

        // Run A: single run, stray start pulse in cycle 20.
        run_log(50, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++)
            check($sformatf("issue_c%0d", vec_c[i]), rdv(vec_c[i]),
                  {1'b1, 4'(vec_a1[i]), 4'(vec_a2[i]), 3'(vec_tw[i]), 2'(vec_st[i])});
        check("wait_c9_zero", rdv(9), 14'd0);
        check("wait_c10_zero", rdv(10), 14'd0);
        check("busy_c0", by2_l[0], 1'b0);
        check("busy_c1", by2_l[1], 1'b1);
        check("busy_c41", by2_l[41], 1'b1);
        check("busy_c42", by2_l[42], 1'b0);
        check("done_c41", dn2_l[41], 1'b1);

        n_rd = 0; n_wr = 0; n_dn = 0; bad = 0; wr_seen = 0;
        n_rd1 = 0; n_wr1 = 0; late_wr1 = 0;
        for (int s = 0; s < 4; s++) begin first_rd[s] = -1; last_wr[s] = -1; end
        for (int c = 0; c < 50; c++) begin
            n_rd += int'(re2_l[c]);
            n_wr += int'(we2_l[c]);
            n_dn += int'(dn2_l[c]);
            n_rd1 += int'(re1_l[c]);
            n_wr1 += int'(we1_l[c]);
            if (c > 36 && we1_l[c]) late_wr1++;
            if (!re2_l[c] && rdv(c) != 14'd0) bad++;
            if (c >= 2) begin
                if (we2_l[c] !== re2_l[c-2]) bad++;
                if (we2_l[c] && (wa1_l[c] !== ra1_l[c-2] || wa2_l[c] !== ra2_l[c-2])) bad++;
            end
            if (c >= 1) begin
                if (we1_l[c] !== re1_l[c-1]) bad++;
                if (we1_l[c] && (w1a1_l[c] !== r1a1_l[c-1] || w1a2_l[c] !== r1a2_l[c-1])) bad++;
            end
            if (re2_l[c] && first_rd[st_l[c]] < 0) first_rd[st_l[c]] = c;
            if (we2_l[c]) begin
                last_wr[wr_seen / 8] = c;
                wr_seen++;
            end
        end
        check("rd_count_p2", n_rd, 32);
        check("wr_count_p2", n_wr, 32);
        check("done_pulses_p2", n_dn, 1);
        check("align_and_idle_violations", bad, 0);
        for (int s = 0; s < 3; s++)
            check($sformatf("hazard_gap_s%0d", s), first_rd[s+1] - last_wr[s], 1);

        check("p1_c9_idle", re1_l[9], 1'b0);
        check("p1_stage1_start_c10", {re1_l[10], r1a1_l[10], r1a2_l[10]}, {1'b1, 4'd0, 4'd4});
        check("p1_last_wr_c36", we1_l[36], 1'b1);
        check("p1_no_wr_after_36", late_wr1, 0);
        check("p1_done_c37", dn1_l[37], 1'b1);
        check("rd_count_p1", n_rd1, 32);
        check("wr_count_p1", n_wr1, 32);

        // Run B: start held high; restart only after passing through IDLE.
        run_log(46, 1'b1, 1'b0);
        check("hold_done_c41", dn2_l[41], 1'b1);
        check("hold_idle_c42", re2_l[42], 1'b0);
        check("hold_restart_c43", rdv(43), {1'b1, 4'd0, 4'd8, 3'd0, 2'd0});
        check("hold_p1_restart_c39", re1_l[39], 1'b1);

        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Run C: reset asserted mid-run in cycle 15, then a fresh start.
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("async_reset_midrun", all_out2(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_wr = 0; n_dn = 0; bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_wr += int'(wr_en2) + int'(wr_en1);
            n_dn += int'(done2) + int'(done1);
            bad  += int'(busy2) + int'(busy1);
        end
        check("after_reset_no_wr", n_wr, 0);
        check("after_reset_no_done", n_dn, 0);
        check("after_reset_not_busy", bad, 0);
        run_log(3, 1'b0, 1'b0);
        check("fresh_start_c1", rdv(1), {1'b1, 4'd0, 4'd8, 3'd0, 2'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
